// File: rtl/if_instruction_memory_pkg.sv
// if_instruction_memory_pkg: shared MIPS widths, NOP encoding and default instruction memory depth
package if_instruction_memory_pkg;
  localparam int ARQUITECTURE_BITS = 32;
  localparam int BYTE_SIZE = 8;
  localparam int IMEM_DEPTH = 64;
  localparam logic [ARQUITECTURE_BITS-1:0] INSTRUCTION_NOP = '0;
endpackage

// File: rtl/if_instruction_memory_packer.sv
// if_instruction_memory_packer: packs loader bytes big-endian into words (clk, rst, en, data -> word, commit)
module if_instruction_memory_packer
  import if_instruction_memory_pkg::*;
#(
  parameter int WORD_SIZE = ARQUITECTURE_BITS,
  parameter int BYTE_W = BYTE_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BYTE_W-1:0]    data,
  output logic [WORD_SIZE-1:0] word,
  output logic                 commit
);
  localparam int NB = WORD_SIZE / BYTE_W;
  localparam int CW = $clog2(NB);
  logic [CW-1:0] byte_cnt;
  logic [WORD_SIZE-BYTE_W-1:0] pack_reg;
  assign word = {pack_reg, data};
  assign commit = en && (byte_cnt == CW'(NB - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      pack_reg <= '0;
    end else if (en) begin
      byte_cnt <= byte_cnt + 1'b1;
      pack_reg <= commit ? '0 : {pack_reg[WORD_SIZE-2*BYTE_W-1:0], data};
    end
  end
endmodule

// File: rtl/if_instruction_memory.sv
// if_instruction_memory: byte-loaded instruction memory with async word read by pc (i_clk, i_reset, i_clear, i_wr_en, i_wr_byte, i_pc -> o_instruction, o_full, o_empty, o_words_loaded)
module if_instruction_memory
  import if_instruction_memory_pkg::*;
#(
  parameter int WORD_SIZE = ARQUITECTURE_BITS,
  parameter int BYTE_W = BYTE_SIZE,
  parameter int MEM_DEPTH = IMEM_DEPTH,
  localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic [BYTE_W-1:0]    i_wr_byte,
  input  logic [WORD_SIZE-1:0] i_pc,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_W:0]      o_words_loaded
);
  logic rst, en, commit, valid, pc_unused;
  logic [WORD_SIZE-1:0] word;
  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W-1:0] idx;
  assign rst = i_reset || i_clear;
  assign en = i_wr_en && !o_full && !rst;
  assign o_full = wr_ptr == (ADDR_W+1)'(MEM_DEPTH);
  assign o_empty = wr_ptr == '0;
  assign o_words_loaded = wr_ptr;
  assign idx = i_pc[ADDR_W+1:2];
  assign pc_unused = ^i_pc[1:0];
  assign valid = (i_pc[WORD_SIZE-1:ADDR_W+2] == '0) && ({1'b0, idx} < wr_ptr);
  assign o_instruction = valid ? mem[idx] : INSTRUCTION_NOP;
  if_instruction_memory_packer #(.WORD_SIZE(WORD_SIZE), .BYTE_W(BYTE_W)) u_packer (
    .clk(i_clk),
    .rst(rst),
    .en(en),
    .data(i_wr_byte),
    .word(word),
    .commit(commit)
  );
  always_ff @(posedge i_clk) begin
    if (rst) wr_ptr <= '0;
    else if (commit) wr_ptr <= wr_ptr + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (commit) mem[wr_ptr[ADDR_W-1:0]] <= word;
  end
endmodule

// File: tb/tb_if_instruction_memory.sv
// tb_if_instruction_memory: directed self-checking bench with a queue scoreboard of expected fetches
module tb_if_instruction_memory;
  localparam int DEPTH = 64;
  logic clk = 0, rst = 1, clr = 0, wr_en = 0;
  logic [7:0] wr_byte = '0;
  logic [31:0] pc = '0, instr;
  logic full, empty;
  logic [6:0] words;
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] pc; logic [31:0] word;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  if_instruction_memory dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_wr_en(wr_en), .i_wr_byte(wr_byte),
    .i_pc(pc), .o_instruction(instr), .o_full(full), .o_empty(empty), .o_words_loaded(words)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1; wr_byte = b;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic load_word(input logic [31:0] w, input int slot);
    for (int i = 3; i >= 0; i--) wr(w[8*i +: 8]);
    q.push_back('{32'(slot * 4), w});
  endtask

  task automatic clear_cycle();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    q.delete();
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      pc = e.pc;
      @(negedge clk);
      check(tag, instr, e.word);
    end
  endtask

  task automatic status(input string tag, input int n, input logic f, input logic e);
    @(negedge clk);
    check({tag, "_words"}, 32'(words), 32'(n));
    check({tag, "_full"}, 32'(full), 32'(f));
    check({tag, "_empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    pc = 0;
    status("reset", 0, 0, 1);
    check("reset_instr", instr, 32'h0);

    load_word(32'h20010005, 0);
    load_word(32'hAC220004, 1);
    status("two_words", 2, 0, 0);
    drain("two_words_read");
    pc = 5; @(negedge clk); check("misaligned_pc5", instr, 32'hAC220004);
    pc = 8; @(negedge clk); check("unwritten_pc8", instr, 32'h0);

    wr(8'hAA); wr(8'hBB); wr(8'hCC);
    clear_cycle();
    status("clear_partial", 0, 0, 1);
    load_word(32'h11223344, 0);
    status("after_clear", 1, 0, 0);
    drain("after_clear_read");

    clear_cycle();
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) begin
        pc = 32'((DEPTH - 1) * 4);
        wr(8'h00); wr(8'h00); wr(8'h00);
        wr_en = 1; wr_byte = 8'(k);
        @(negedge clk);
        check("commit_old_value", instr, 32'h0);
        @(posedge clk); #1;
        wr_en = 0;
        q.push_back('{32'(k * 4), 32'(k)});
      end else load_word(32'(k), k);
    end
    status("full", DEPTH, 1, 0);
    repeat (4) wr(8'hFF);
    status("full_overflow", DEPTH, 1, 0);
    pc = 0; @(negedge clk); check("full_mem0", instr, 32'h0);
    drain("full_read");

    pc = DEPTH * 4; @(negedge clk); check("pc_past_depth", instr, 32'h0);
    pc = 32'h0001_0004; @(negedge clk); check("pc_high_bits", instr, 32'h0);
    pc = 20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pc_hold", instr, 32'd5);
    end

    clear_cycle();
    load_word(32'h01020304, 0);
    load_word(32'h05060708, 1);
    clr = 1; wr_en = 1; wr_byte = 8'hEE;
    @(posedge clk); #1;
    clr = 0; wr_en = 0;
    q.delete();
    status("clear_vs_wr", 0, 0, 1);
    pc = 0; @(negedge clk); check("clear_vs_wr_instr", instr, 32'h0);
    load_word(32'hDEADBEEF, 0);
    status("reload", 1, 0, 0);
    drain("reload_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end
endmodule
